// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM states and default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } mdu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// E-stage multiply/divide unit holding HI/LO, with a counter-modelled latency.
// Optional MADD/MADDU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_hi,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;

  mdu_op_t op_e;
  assign op_e = mdu_op_t'(op);

  // Products in 64-bit context.
  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Divisor forced to 1 for divide-by-zero and for 0x80000000 / -1; the
  // latter then yields exactly quotient 0x80000000, remainder 0.
  logic        div_zero, div_ovf;
  logic [31:0] safe_b;
  logic signed [31:0] a_s, b_s, q_s, r_s;
  logic [31:0] q_u, r_u;
  assign div_zero = (B == 32'd0);
  assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign safe_b   = (div_zero || div_ovf) ? 32'd1 : B;
  assign a_s      = A;
  assign b_s      = safe_b;
  assign q_s      = a_s / b_s;
  assign r_s      = a_s % b_s;
  assign q_u      = A / safe_b;
  assign r_u      = A % safe_b;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_e)
            OP_MULT: begin
              {hi_pend_d, lo_pend_d} = prod_s;
              cnt_d   = MULT_LOAD;
              state_d = ST_RUN;
            end
            OP_MULTU: begin
              {hi_pend_d, lo_pend_d} = prod_u;
              cnt_d   = MULT_LOAD;
              state_d = ST_RUN;
            end
            OP_DIV: begin
              // A zero divisor re-commits the current HI/LO unchanged.
              hi_pend_d = div_zero ? hi_q : r_s;
              lo_pend_d = div_zero ? lo_q : q_s;
              cnt_d     = DIV_LOAD;
              state_d   = ST_RUN;
            end
            OP_DIVU: begin
              hi_pend_d = div_zero ? hi_q : r_u;
              lo_pend_d = div_zero ? lo_q : q_u;
              cnt_d     = DIV_LOAD;
              state_d   = ST_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              {hi_pend_d, lo_pend_d} = {hi_q, lo_q} + prod_s;
              cnt_d   = MULT_LOAD;
              state_d = ST_RUN;
            end
            OP_MADDU: begin
              {hi_pend_d, lo_pend_d} = {hi_q, lo_q} + prod_u;
              cnt_d   = MULT_LOAD;
              state_d = ST_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          hi_d    = hi_pend_q;
          lo_d    = lo_pend_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign rdata = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu with hand-computed HI/LO results.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        rd_hi;
  logic [31:0] rdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .rd_hi(rd_hi), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    rd_hi = 1'b1; #1 hi = rdata;
    rd_hi = 1'b0; #1 lo = rdata;
  endtask

  // Present one op for one rising edge, then count busy cycles (bounded).
  task automatic run_op(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0; A = '0; B = '0;
    cycles = 0;
    while (busy && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0; rd_hi = 1'b0;
    repeat (2) @(negedge clk);
    read_hilo(hi, lo);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo;
    int cyc;
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, cyc);
    read_hilo(hi, lo);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL mult_busy: got %0d expected 5", cyc); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffe", lo); end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, cyc);
    read_hilo(hi, lo);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL multu_busy: got %0d expected 5", cyc); end
    n_checks++; if (hi !== 32'h1) begin n_fail++; $display("FAIL multu_hi: got %h expected 1", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
  endtask

  task automatic test_div();
    logic [31:0] hi, lo;
    int cyc;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    read_hilo(hi, lo);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL div_busy: got %0d expected 10", cyc); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    run_op(OP_DIVU, 32'd7, 32'd2, cyc);
    read_hilo(hi, lo);
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_lo: got %h expected 3", lo); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu_hi: got %h expected 1", hi); end
    // 7 / -2 = -3 remainder 1 (remainder follows the dividend).
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, cyc);
    read_hilo(hi, lo);
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb_lo: got %h expected fffffffd", lo); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL div_negb_hi: got %h expected 1", hi); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    read_hilo(hi, lo);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 0", hi); end
  endtask

  task automatic test_div_zero();
    logic [31:0] hi, lo;
    int cyc;
    run_op(OP_MTHI, 32'd5, 32'd0, cyc);
    run_op(OP_MTLO, 32'd9, 32'd0, cyc);
    run_op(OP_DIV, 32'd1234, 32'd0, cyc);
    read_hilo(hi, lo);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL div0_busy: got %0d expected 10", cyc); end
    n_checks++; if (hi !== 32'd5) begin n_fail++; $display("FAIL div0_hi: got %h expected 5", hi); end
    n_checks++; if (lo !== 32'd9) begin n_fail++; $display("FAIL div0_lo: got %h expected 9", lo); end
  endtask

  task automatic test_mt();
    logic [31:0] hi, lo;
    int cyc;
    run_op(OP_MTLO, 32'h1234, 32'd0, cyc);
    read_hilo(hi, lo);
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL mtlo_busy: got %0d expected 0", cyc); end
    n_checks++; if (lo !== 32'h1234) begin n_fail++; $display("FAIL mtlo_lo: got %h expected 1234", lo); end
    n_checks++; if (hi !== 32'd5) begin n_fail++; $display("FAIL mtlo_hi: got %h expected 5", hi); end
  endtask

  // A start pulse during busy must be ignored, and HI/LO must not move
  // before the operation completes.
  task automatic test_ignore_while_busy();
    logic [31:0] hi, lo;
    int cyc;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; A = 32'd3; B = 32'd4;
    @(negedge clk);
    op = OP_MTLO; A = 32'hDEAD;
    read_hilo(hi, lo);
    n_checks++; if (lo !== 32'h1234) begin n_fail++; $display("FAIL busy_lo_held: got %h expected 1234", lo); end
    repeat (2) @(negedge clk);
    start = 1'b0; op = 3'd0; A = '0; B = '0;
    cyc = 0;
    while (busy && cyc < 50) begin cyc++; @(negedge clk); end
    read_hilo(hi, lo);
    n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL ignore_lo: got %h expected c", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL ignore_hi: got %h expected 0", hi); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    int cyc;
    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, cyc);
    read_hilo(hi, lo);
    n_checks++; if (hi !== 32'd1 || lo !== 32'd0) begin n_fail++; $display("FAIL b2b_mult: got %h_%h expected 00000001_00000000", hi, lo); end
    run_op(OP_DIVU, 32'd100, 32'd7, cyc);
    read_hilo(hi, lo);
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL b2b_divu_lo: got %h expected e", lo); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_divu_hi: got %h expected 2", hi); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    int cyc;
    run_op(OP_MTHI, 32'h55, 32'd0, cyc);
    run_op(OP_MTLO, 32'h66, 32'd0, cyc);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; A = 32'd100; B = 32'd3;
    @(negedge clk);
    start = 1'b0; op = 3'd0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    read_hilo(hi, lo);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rstmid_hilo: got %h_%h expected 0_0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    read_hilo(hi, lo);
    n_checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_late: got busy=%b %h_%h expected 0 0_0", busy, hi, lo);
    end
  endtask

  task automatic test_madd();
    logic [31:0] hi, lo;
    int cyc;
    run_op(OP_MTHI, 32'd0, 32'd0, cyc);
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, cyc);
    run_op(OP_MADDU, 32'd1, 32'd1, cyc);
    read_hilo(hi, lo);
`ifdef MDU_MADD_EN
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL maddu_busy: got %0d expected 5", cyc); end
    n_checks++; if (hi !== 32'd1 || lo !== 32'd0) begin n_fail++; $display("FAIL maddu_hilo: got %h_%h expected 00000001_00000000", hi, lo); end
    run_op(OP_MADD, 32'hFFFF_FFFF, 32'd1, cyc);
    read_hilo(hi, lo);
    n_checks++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL madd_hilo: got %h_%h expected 00000000_ffffffff", hi, lo); end
`else
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL maddu_nop_busy: got %0d expected 0", cyc); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL maddu_nop_hilo: got %h_%h expected 00000000_ffffffff", hi, lo); end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mt();
    test_ignore_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_madd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the five-stage pipelined CPU. It sits in the E stage beside the ALU and takes the same forwarded operands (ALU_A/ALU_B after the forwarding muxes). It holds the architectural HI/LO registers, runs multi-cycle MULT/MULTU/DIV/DIVU operations, and reports `busy` to the hazard unit (CBT), which stalls dependent HI/LO instructions. Its read result joins the ALU result on its way into the M pipeline register.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (≥1).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: E-stage instruction is an MDU op; qualifies `op`.
- `op` in 3: operation code from `mdu_pkg`.
- `A` in 32: rs operand, already forwarded.
- `B` in 32: rt operand, already forwarded.
- `rd_hi` in 1: read select, 1 = HI, 0 = LO (MFHI/MFLO).
- `rdata` out 32: HI or LO per `rd_hi`; combinational.
- `busy` out 1: multi-cycle operation in progress.

## Operation
- Ops: MULT, MULTU, DIV, DIVU, MTHI, MTLO (plus MADD and MADDU under the macro).
- `start` is sampled only when `busy`=0. The hazard unit guarantees `start`=0 while busy. If `start` is asserted while busy anyway, it is ignored.
- MULT/MULTU: the 64-bit product {HI,LO} = A×B, signed or unsigned respectively.
- DIV/DIVU: LO = quotient and HI = remainder, signed or unsigned. Signed division truncates toward zero, and the remainder takes the sign of the dividend.
- DIV with A=32'h80000000 and B=32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- Divide by zero (B=0): HI/LO stay unchanged. `busy` still runs the full DIV_CYCLES.
- At `start`, the result is computed combinationally from A/B and latched into internal `hi_pend`/`lo_pend` along with the cycle count. HI/LO themselves stay unchanged until the operation completes.
- MTHI/MTLO write A into HI/LO at the sampling edge. They take one cycle, and `busy` is never raised.
- State machine:
  - IDLE → RUN when a multi-cycle op starts; counter loads N−1.
  - RUN: the counter decrements each cycle.
  - RUN at counter 0 → IDLE; HI/LO ← pending values on that edge.
- `rdata` always reflects the committed HI/LO, never the pending values.

## Timing
- Reset values: HI=0, LO=0, `busy`=0, counter=0, state IDLE, `rdata`=0.
- Start sampled at edge e0: `busy`=1 from e0 until edge e0+N, where N is MULT_CYCLES or DIV_CYCLES.
- HI/LO update at e0+N, and `busy` falls at that same edge.
- An MFHI/MFLO issued in the cycle after `busy` falls reads the new value.
- The hazard unit must stall on `start`|`busy` for MFHI/MFLO/MTHI/MTLO/MDU ops. `busy` is not yet high in the start cycle itself.
- Reset mid-operation: the operation is abandoned immediately, with HI/LO=0 and `busy`=0.
- A pipeline stall or E-clear does not cancel an operation already started.

## Configuration
- `MDU_MADD_EN` defined: adds MADD/MADDU. {HI,LO} ← {HI,LO} + A×B (signed or unsigned, modulo 2^64) with MULT_CYCLES latency. The accumulator base is the committed HI/LO at `start`.
- `MDU_MADD_EN` undefined: the MADD/MADDU encodings behave as no-op, with no state change and no `busy`.

## Structure
- `mdu_pkg` holds:
  - the `mdu_op_t` encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MADDU=7;
  - the default cycle constants.
- One module `mdu`, with no sub-module. Arithmetic uses behavioural `*`, `/` and `%`; latency is modelled by the counter.

## Test plan
- Reset, then MULT A=32'hFFFFFFFF, B=2: `busy` is high for 5 cycles, then HI=32'hFFFFFFFF and LO=32'hFFFFFFFE. MULTU with the same operands gives HI=1, LO=32'hFFFFFFFE.
- DIV A=−7 (32'hFFFFFFF9), B=2: after 10 cycles LO=32'hFFFFFFFD and HI=32'hFFFFFFFF. DIVU 7/2 gives LO=3, HI=1.
- DIV with B=0 after MTHI 5 and MTLO 9: `busy` lasts 10 cycles, and HI=5, LO=9 afterwards.
- MTLO 32'h1234 → `rd_hi`=0 gives `rdata`=32'h1234 on the next cycle, and `busy` never rises.
- Start DIV, then assert `reset` at cycle 4: `busy`=0, HI=LO=0 immediately, and nothing commits later.
- With `MDU_MADD_EN`: HI=0, LO=32'hFFFFFFFF, then MADDU 1×1 gives HI=1, LO=0. Without the macro, the same stimulus leaves HI/LO unchanged.
